cpu_hazard_scoreboard: RTL and testbench

Parametrised hazard detection unit with an internal scoreboard of in-flight long-latency (multiplier) writes. It replaces fixed per-slot comparators with a MUL_LAT-deep shift tracker. The tracker adds optional r0 exclusion, separate ra/rb use qualification, and a saturating stall-cycle counter. The block sits beside decode and drives fetch/decode stall, execute bubble insertion and the global freeze.

---
 rtl/cpu_hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_cpu_hazard_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hazard_scoreboard.sv
// Hazard detection unit with a MUL_LAT-deep tracker of in-flight multiplier writes.
// Drives fetch/decode stall, execute bubble, global freeze and a stall-cycle counter.
module cpu_hazard_scoreboard #(
  parameter int REG_ID_W    = 5,
  parameter int MUL_LAT     = 5,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                decode_valid,
  input  logic [REG_ID_W-1:0] decode_ra,
  input  logic [REG_ID_W-1:0] decode_rb,
  input  logic [REG_ID_W-1:0] decode_rd,
  input  logic                ra_use,
  input  logic                rb_use,
  input  logic                rd_use,
  input  logic                decode_is_mul,
  input  logic                branch_decode,
  input  logic                jump_decode,
  input  logic [REG_ID_W-1:0] execute_rd,
  input  logic                execute_wb,
  input  logic                execute_mem_read,
  input  logic [REG_ID_W-1:0] commit_rd,
  input  logic                commit_mem_read,
  input  logic                cache_miss,
  output logic                f_stall,
  output logic                d_stall,
  output logic                e_nop,
  output logic                e_stall,
  output logic                busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [MUL_LAT-1:0]  v_q;
  logic [REG_ID_W-1:0] rd_q [MUL_LAT];
  logic [CNT_W-1:0]    cnt_q;

  logic ra_ok, rb_ok, rd_ok;
  logic hit_ra, hit_rb, hit_rd;
  logic raw_mul, waw_mul, load_use;
  logic br_alu, jmp_alu, br_load, jmp_load;
  logic frz, nop, stl, issue;

  // Register 0 is hardwired, so it can never carry a dependency
  assign ra_ok = !(ZERO_REG_EN != 0 && decode_ra == '0);
  assign rb_ok = !(ZERO_REG_EN != 0 && decode_rb == '0);
  assign rd_ok = !(ZERO_REG_EN != 0 && decode_rd == '0);

  always_comb begin
    hit_ra = 1'b0;
    hit_rb = 1'b0;
    hit_rd = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      if (v_q[i] && rd_q[i] == decode_ra) hit_ra = 1'b1;
      if (v_q[i] && rd_q[i] == decode_rb) hit_rb = 1'b1;
      if (v_q[i] && rd_q[i] == decode_rd) hit_rd = 1'b1;
    end
  end

  assign raw_mul = decode_valid &
                   ((ra_use & ra_ok & hit_ra) |
                    (rb_use & rb_ok & hit_rb));
  assign waw_mul = decode_valid & rd_use &
                   !decode_is_mul & rd_ok & hit_rd;

  assign load_use = execute_mem_read &
    ((ra_use & ra_ok & (execute_rd == decode_ra)) |
     (rb_use & rb_ok & (execute_rd == decode_rb)));

  assign br_alu = branch_decode & execute_wb &
    ((ra_ok & (execute_rd == decode_ra)) |
     (rb_ok & (execute_rd == decode_rb)));
  assign jmp_alu = jump_decode & execute_wb &
    ra_ok & (execute_rd == decode_ra);

  assign br_load = branch_decode & commit_mem_read &
    ((ra_ok & (commit_rd == decode_ra)) |
     (rb_ok & (commit_rd == decode_rb)));
  assign jmp_load = jump_decode & commit_mem_read &
    ra_ok & (commit_rd == decode_ra);

  // Every hazard output reads 0 while reset is held
  assign frz = rst_n & (cache_miss | br_load | jmp_load);
  assign nop = rst_n &
    (raw_mul | waw_mul | load_use | br_alu | jmp_alu);
  assign stl = frz | nop;

  assign issue = decode_valid & decode_is_mul & rd_use & !stl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) rd_q[i] <= '0;
    end else begin
      if (!frz) begin
        v_q[0]  <= issue;
        rd_q[0] <= decode_rd;
        for (int i = 1; i < MUL_LAT; i++) begin
          v_q[i]  <= v_q[i-1];
          rd_q[i] <= rd_q[i-1];
        end
      end
      if (stl && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign e_stall   = frz;
  assign e_nop     = nop;
  assign d_stall   = stl;
  assign f_stall   = stl;
  assign busy      = rst_n & (|v_q);
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Randomised and directed bench for cpu_hazard_scoreboard.
// A list of in-flight multiplies with ages serves as the reference.
module tb_cpu_hazard_scoreboard;
  localparam int RW  = 5;
  localparam int L   = 5;
  localparam int ZEN = 1;
  localparam int CW  = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0, rst_n = 0;
  logic dv, ra_u, rb_u, rd_u, is_mul, br, jmp;
  logic ewb, emr, cmr, cm;
  logic [RW-1:0] ra, rb, rd, er, cr;
  logic fs, ds, en, es, bsy;
  logic [CW-1:0] cnt;
  logic fs2, ds2, en2, es2, bsy2;
  logic [CW-1:0] cnt2;

  always #5 clk = ~clk;

  cpu_hazard_scoreboard #(.REG_ID_W(RW), .MUL_LAT(L),
    .ZERO_REG_EN(ZEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .decode_valid(dv),
    .decode_ra(ra), .decode_rb(rb), .decode_rd(rd),
    .ra_use(ra_u), .rb_use(rb_u), .rd_use(rd_u),
    .decode_is_mul(is_mul), .branch_decode(br),
    .jump_decode(jmp), .execute_rd(er), .execute_wb(ewb),
    .execute_mem_read(emr), .commit_rd(cr),
    .commit_mem_read(cmr), .cache_miss(cm),
    .f_stall(fs), .d_stall(ds), .e_nop(en), .e_stall(es),
    .busy(bsy), .stall_cnt(cnt));

  cpu_hazard_scoreboard #(.REG_ID_W(RW), .MUL_LAT(L),
    .ZERO_REG_EN(0), .CNT_W(CW)) dut_nz (
    .clk(clk), .rst_n(rst_n), .decode_valid(dv),
    .decode_ra(ra), .decode_rb(rb), .decode_rd(rd),
    .ra_use(ra_u), .rb_use(rb_u), .rd_use(rd_u),
    .decode_is_mul(is_mul), .branch_decode(br),
    .jump_decode(jmp), .execute_rd(er), .execute_wb(ewb),
    .execute_mem_read(emr), .commit_rd(cr),
    .commit_mem_read(cmr), .cache_miss(cm),
    .f_stall(fs2), .d_stall(ds2), .e_nop(en2), .e_stall(es2),
    .busy(bsy2), .stall_cnt(cnt2));

  typedef struct { int rd; int age; } ent_t;
  ent_t inflight[$];
  int m_cnt;
  int checks = 0, failures = 0;
  int o_fs, o_ds, o_en, o_es, o_bsy, o_cnt, o2_ds;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit zr(int id);
    return ZEN != 0 && id == 0;
  endfunction

  function automatic bit pend(int id);
    if (zr(id)) return 0;
    foreach (inflight[i]) if (inflight[i].rd == id) return 1;
    return 0;
  endfunction

  task automatic idle();
    dv = 0; ra_u = 0; rb_u = 0; rd_u = 0; is_mul = 0;
    br = 0; jmp = 0; ewb = 0; emr = 0; cmr = 0; cm = 0;
    ra = 0; rb = 0; rd = 0; er = 0; cr = 0;
  endtask

  // Compare on the falling edge, then advance the model to the next rise
  task automatic step();
    bit raw, waw, lu, bra, jma, brl, jml;
    bit x_es, x_en, x_ds;
    int a, b, d, e, c;
    @(negedge clk);
    o_fs = fs; o_ds = ds; o_en = en; o_es = es;
    o_bsy = bsy; o_cnt = cnt; o2_ds = ds2;
    a = ra; b = rb; d = rd; e = er; c = cr;
    if (!rst_n) begin
      inflight.delete();
      m_cnt = 0;
      x_es = 0; x_en = 0; x_ds = 0;
    end else begin
      raw = dv && ((ra_u && pend(a)) || (rb_u && pend(b)));
      waw = dv && rd_u && !is_mul && pend(d);
      lu  = emr && ((ra_u && e == a && !zr(a)) ||
                    (rb_u && e == b && !zr(b)));
      bra = br && ewb && ((e == a && !zr(a)) ||
                          (e == b && !zr(b)));
      jma = jmp && ewb && e == a && !zr(a);
      brl = br && cmr && ((c == a && !zr(a)) ||
                          (c == b && !zr(b)));
      jml = jmp && cmr && c == a && !zr(a);
      x_es = cm || brl || jml;
      x_en = raw || waw || lu || bra || jma;
      x_ds = x_es || x_en;
    end
    chk("e_stall", o_es, x_es);
    chk("e_nop", o_en, x_en);
    chk("d_stall", o_ds, x_ds);
    chk("f_stall", o_fs, x_ds);
    chk("busy", o_bsy, rst_n && inflight.size() > 0);
    chk("stall_cnt", o_cnt, m_cnt);
    if (rst_n) begin
      if (!x_es) begin
        foreach (inflight[i]) inflight[i].age++;
        while (inflight.size() > 0 && inflight[0].age >= L)
          void'(inflight.pop_front());
        if (dv && is_mul && rd_u && !x_ds)
          inflight.push_back('{rd: d, age: 0});
      end
      if (x_ds && m_cnt < CMAX) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic mul_to(int r);
    idle();
    dv = 1; is_mul = 1; rd_u = 1; rd = RW'(r);
    step();
  endtask

  task automatic add_dep(int r);
    idle();
    dv = 1; ra_u = 1; rb_u = 1; rd_u = 1;
    ra = RW'(r); rb = 5'd1; rd = 5'd4;
  endtask

  initial begin
    int k;
    idle();
    m_cnt = 0;
    #1;
    step();
    rst_n = 1;

    // Reset mid-stream with three entries in flight
    mul_to(1); mul_to(2); mul_to(3);
    idle();
    chk("busy_before_rst", bsy, 1);
    dv = 1; ra_u = 1; ra = 5'd2;
    rst_n = 0;
    step();
    chk("rst_dstall", o_ds, 0);
    chk("rst_busy", o_bsy, 0);
    rst_n = 1;
    idle();
    step();
    chk("post_rst_busy", o_bsy, 0);
    chk("post_rst_cnt", o_cnt, 0);
    chk("post_rst_stall", o_ds | o_es | o_en, 0);

    // Multiply latency: dependent stalls MUL_LAT cycles
    do_reset();
    mul_to(3);
    add_dep(3);
    k = 0;
    while (k < 20) begin
      step();
      if (!o_ds) break;
      k++;
    end
    chk("mul_lat_stalls", k, 5);
    chk("mul_lat_cnt", o_cnt, 5);

    // Same with a cache miss in the third stalled cycle
    do_reset();
    mul_to(3);
    add_dep(3);
    k = 0;
    while (k < 20) begin
      cm = (k == 2);
      step();
      if (!o_ds) break;
      k++;
    end
    chk("miss_stalls", k, 6);
    chk("miss_cnt", o_cnt, 6);

    // Load-use only when the operand is actually used
    do_reset();
    idle();
    emr = 1; er = 5'd7;
    dv = 1; rb = 5'd7; rb_u = 1; ra = 5'd2;
    step();
    chk("load_use_rb", o_en, 1);
    rb_u = 0;
    step();
    chk("load_use_unused", o_ds, 0);

    // r0 never blocks here, but blocks in the ZERO_REG_EN=0 copy
    do_reset();
    mul_to(0);
    add_dep(0);
    k = 0;
    while (k < 20) begin
      step();
      if (k == 0) chk("r0_no_stall", o_ds, 0);
      if (!o2_ds) break;
      k++;
    end
    chk("r0_nz_stalls", k, 5);

    // Branch against a committing load freezes the pipe
    do_reset();
    idle();
    br = 1; ra = 5'd2; rb = 5'd6;
    cmr = 1; cr = 5'd2;
    step();
    chk("br_load_estall", o_es, 1);

    // Non-mul writing the same rd waits for retirement
    do_reset();
    mul_to(9);
    idle();
    dv = 1; rd_u = 1; rd = 5'd9;
    k = 0;
    while (k < 20) begin
      step();
      if (!o_ds) break;
      k++;
    end
    chk("waw_stalls", k, 5);

    // Back-to-back multiplies to the same rd are not stalled
    do_reset();
    mul_to(9);
    mul_to(9);
    chk("mul_waw_nostall", o_ds, 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      dv = ($urandom % 4) != 0;
      ra = RW'($urandom % 8);
      rb = RW'($urandom % 8);
      rd = RW'($urandom % 8);
      er = RW'($urandom % 8);
      cr = RW'($urandom % 8);
      ra_u = $urandom % 2;
      rb_u = $urandom % 2;
      rd_u = ($urandom % 4) != 0;
      is_mul = ($urandom % 3) == 0;
      br = ($urandom % 8) == 0;
      jmp = ($urandom % 8) == 0;
      ewb = $urandom % 2;
      emr = ($urandom % 4) == 0;
      cmr = ($urandom % 4) == 0;
      cm = ($urandom % 16) == 0;
      rst_n = ($urandom % 300) != 0;
      step();
      rst_n = 1;
    end

    // Saturation of the stall counter
    idle();
    cm = 1;
    for (int n = 0; n < CMAX + 5; n++) step();
    chk("cnt_saturated", o_cnt, CMAX);
    idle();
    step();
    chk("cnt_hold", o_cnt, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
